// File: rtl/seg_scan_pkg.sv
// Shared constants, scan FSM encoding and the width helper for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [0:6]            SEG_BLANK = 7'b1111111;
    localparam logic [MAX_DIGITS-1:0] AN_OFF    = '1;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Minimum one bit so single-value counters still have a legal width.
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_sevenseg.sv
// Hex nibble to active-low seven-segment glyph, segments a..g in bit order [0:6].
// Purely combinational; the caller registers the result.
module seg_scan_ctrl_sevenseg
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [0:6] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-coherent shadow digits; SEG_SCAN_BLINK_EN adds blink_mask flashing.
// Outputs are registered one cycle behind the scan state; update_req is level-sensitive and only served at frame end.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    input  logic                    update_req,
    output logic                    update_ack,
    output logic [0:6]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam int IDX_W = clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS || BLANK_CYCLES < 1 ||
        PRESCALE <= BLANK_CYCLES || BLINK_FRAMES < 1) begin : g_bad_params
        $error("seg_scan_ctrl: illegal parameter combination");
    end

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    scan_state_e             r_state;
    logic [4*NUM_DIGITS-1:0] r_shadow;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_load;
    logic [NUM_DIGITS-1:0]   w_en_eff;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [3:0]              w_nibble;
    logic                    w_digit_on;
    logic [0:6]              w_seg;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_load      = w_frame_end && update_req;

`ifdef SEG_SCAN_BLINK_EN
    localparam int              FRM_W    = clog2(BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] r_frame;
    logic             r_blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frame == FRM_LAST) begin
                r_frame       <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    // Blinking digits go dark during the odd half-period, exactly as if digit_en were low.
    assign w_en_eff = digit_en & ~(blink_mask & {NUM_DIGITS{r_blink_phase}});
`else
    assign w_en_eff = digit_en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= BLANK;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                BLANK: if (r_cnt == BLANK_LAST) r_state <= SHOW;
                SHOW:  if (w_slot_end)          r_state <= BLANK;
                default:                        r_state <= BLANK;
            endcase
        end
    end

    // Shadow only changes on the last cycle of a frame, so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_load) begin
            r_shadow <= digits_in;
        end
    end

    always_comb begin
        w_nibble   = 4'h0;
        w_digit_on = 1'b0;
        w_an       = AN_ALL_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble   = r_shadow[4*k +: 4];
                w_digit_on = w_en_eff[k];
                w_an[k]    = 1'b0;
            end
        end
    end

    seg_scan_ctrl_sevenseg u_sevenseg (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out    <= SEG_BLANK;
            an_out     <= AN_ALL_OFF;
            update_ack <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame_end;
            update_ack <= w_load;
            if (r_state == SHOW && w_digit_on) begin
                an_out  <= w_an;
                seg_out <= w_seg;
            end else begin
                an_out  <= AN_ALL_OFF;
                seg_out <= SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(~an_out));
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based model predicts every output cycle, a negedge monitor compares.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int PRE   = 8;
    localparam int BLK   = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * PRE;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   digit_en;
    logic            update_req;
    logic            update_ack;
    logic [0:6]      seg_out;
    logic [ND-1:0]   an_out;
    logic            frame_tick;
`ifdef SEG_SCAN_BLINK_EN
    logic [ND-1:0]   blink_mask;
`endif

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PRE),
        .BLANK_CYCLES (BLK),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .update_req (update_req),
        .update_ack (update_ack),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [0:6]    seg;
        logic [ND-1:0] an;
        logic          ack;
        logic          tick;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              m_t      = 0;
    int              n_rel    = 0;
    logic [4*ND-1:0] m_shadow = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [0:6] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Predicts the outputs produced by the next clock edge from elapsed time since reset.
    task automatic drive_cycle();
        exp_t          e;
        int            idx;
        int            cnt;
        logic [ND-1:0] en;
        e.seg  = 7'b1111111;
        e.an   = '1;
        e.ack  = 1'b0;
        e.tick = 1'b0;
        if (reset) begin
            m_t      = 0;
            m_shadow = '0;
        end else begin
            idx = (m_t / PRE) % ND;
            cnt = m_t % PRE;
            en  = digit_en;
`ifdef SEG_SCAN_BLINK_EN
            if (((m_t / FRAME) / BF) % 2 == 1) en = en & ~blink_mask;
`endif
            e.tick = (m_t % FRAME == FRAME - 1);
            e.ack  = e.tick && update_req;
            if (cnt >= BLK && en[idx]) begin
                e.an[idx] = 1'b0;
                e.seg     = glyph(m_shadow[4*idx +: 4]);
            end
            if (e.ack) m_shadow = digits_in;
            m_t++;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_rel = reset ? 0 : n_rel + 1;
    endtask

    task automatic run(input int n);
        repeat (n) drive_cycle();
    endtask

    task automatic wait_ack(input string tag, output int at);
        bit got;
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            drive_cycle();
            if (update_ack) begin
                got = 1'b1;
                at  = n_rel;
            end
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("seg_out", 32'(seg_out), 32'(mon_e.seg));
            chk("an_out", 32'(an_out), 32'(mon_e.an));
            chk("update_ack", 32'(update_ack), 32'(mon_e.ack));
            chk("frame_tick", 32'(frame_tick), 32'(mon_e.tick));
            chk("an_onehot0", 32'($onehot0(~an_out)), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int at, a1, a2, a3;
        reset      = 1'b1;
        digits_in  = '0;
        digit_en   = '1;
        update_req = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0001;
`endif
        run(3);

        // Scan into the SHOW phase of digit 2, then reset mid-slot.
        reset = 1'b0;
        run(2 * PRE + BLK + 2);
        reset = 1'b1;
        run(1);

        // First load right after release: ack lands one full frame later.
        reset      = 1'b0;
        digits_in  = 16'h1234;
        update_req = 1'b1;
        wait_ack("ack_after_reset", at);
        update_req = 1'b0;
        chk("ack_latency", 32'(at), 32'(FRAME));
        run(FRAME + 4);

        // Partially enabled digits with a new glyph set.
        digits_in  = 16'hABCD;
        digit_en   = 4'b0101;
        update_req = 1'b1;
        wait_ack("ack_abcd", at);
        update_req = 1'b0;
        run(FRAME + 2);

        // Request held across three frames while the value changes mid-frame.
        digit_en   = '1;
        digits_in  = 16'h0000;
        update_req = 1'b1;
        wait_ack("ack_hold_1", a1);
        run(12);
        digits_in = 16'h0099;
        wait_ack("ack_hold_2", a2);
        wait_ack("ack_hold_3", a3);
        update_req = 1'b0;
        chk("ack_spacing_12", 32'(a2 - a1), 32'(FRAME));
        chk("ack_spacing_23", 32'(a3 - a2), 32'(FRAME));
        run(FRAME + 2);

        // Live digit_en and level requests varying every cycle.
        repeat (4 * FRAME) begin
            digit_en   = ND'($urandom);
            digits_in  = 16'($urandom);
            update_req = 1'($urandom_range(0, 1));
            drive_cycle();
        end

        digit_en   = '1;
        update_req = 1'b0;
        run(6 * FRAME);

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the oven front panel's multi-digit seven-segment display.
- Holds a frame-coherent shadow copy of the digit values and steps through the digits in turn.
- Drives one shared hex-to-seven-segment decoder (sevenSeg instance) and the active-low common-anode enables.
- Inserts a blanking gap between digits to suppress ghosting.
- Accepts new display values from the oven timer/temperature logic over a req/ack handshake, applied only at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at slot start with all anodes off.
- BLINK_FRAMES, 64, frames per blink half-period; used only with BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  nibble k = digit k value, 0..15; digit 0 is rightmost.
- digit_en  in  NUM_DIGITS  live per-digit enable; 0 = digit dark.
- update_req  in  1  level request to load digits_in into the shadow register.
- update_ack  out  1  one-cycle pulse when the shadow register loads.
- seg_out  out  7 ([0:6])  segments a..g, active-low.
- an_out  out  NUM_DIGITS  anode enables, active-low.
- frame_tick  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset: synchronous, active-high, on clk.
  - idx=0, cnt=0, state=BLANK, shadow=0.
  - seg_out=7'b1111111, an_out=all ones.
  - update_ack=0, frame_tick=0.
  - Reset mid-scan aborts the slot; no ack is issued for a pending request.
- Counters:
  - cnt counts 0..PRESCALE-1, then wraps to 0.
  - On the wrap, idx increments; it wraps NUM_DIGITS-1 -> 0.
- FSM:
  - BLANK while cnt < BLANK_CYCLES; SHOW otherwise.
  - BLANK->SHOW when cnt == BLANK_CYCLES-1.
  - SHOW->BLANK on cnt wrap.
- Outputs are registered. Values at cycle t+1 are a function of (state, idx, cnt, shadow, digit_en) at cycle t.
  - BLANK: an_out = all ones; seg_out = 7'b1111111.
  - SHOW with digit_en[idx]=1: an_out[idx]=0, others 1; seg_out = decode(shadow nibble idx).
  - SHOW with digit_en[idx]=0: an_out = all ones; seg_out = 7'b1111111.
  - Never more than one an_out bit low.
- Frame end is the cycle where idx == NUM_DIGITS-1 and cnt == PRESCALE-1.
  - frame_tick is high for exactly the following cycle.
  - If update_req=1 at frame end: shadow <= digits_in and update_ack is high for the following cycle.
  - New values are displayed starting with digit 0 of the next frame.
- Handshake: the requester holds update_req until it sees update_ack, then deasserts.
  - If update_req is still high at the next frame end, a second load and ack occur. Behaviour is level-sensitive by design.
  - digits_in changes while a request is pending: the value present at the frame-end cycle is captured.
- digit_en is sampled live, not shadowed.
- Decode map: standard hex glyphs 0-9, A, b, C, d, E, F, identical to the existing team decoder.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask [NUM_DIGITS-1:0].
  - Adds a frame counter 0..BLINK_FRAMES-1 and a blink_phase flop; both reset to 0.
  - blink_phase toggles when the frame counter wraps at frame end.
  - While blink_phase=1, digits with blink_mask set are treated as digit_en=0.
  - Used for the "cook done" flashing display.
- Undefined: port, counter and phase logic are absent; behaviour is exactly as above.

Decomposition:
- Package seg_scan_pkg holds:
  - SEG_BLANK = 7'b1111111.
  - AN_OFF helper.
  - FSM state enum {BLANK, SHOW}.
  - Width function clog2 for the cnt and idx widths.
- One sub-module: the existing sevenSeg hex decoder, instantiated once and fed from a mux of shadow nibbles.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
1. Reset mid-SHOW of digit 2 -> next cycle an_out=4'b1111 and seg_out=7'b1111111; after release, digit 0 scans first with shadow=0, giving seg_out=7'b0000001 during SHOW.
2. update_req=1 with digits_in=16'h1234 and digit_en=4'b1111 -> one update_ack and one frame_tick 32 cycles after reset release. Next frame shows:
   - digit 0: an_out=4'b1110, seg_out=7'b1001100 ("4").
   - digit 3: an_out=4'b0111, seg_out=7'b1001111 ("1").
3. Slot timing -> each slot shows 2 cycles of an_out=1111 followed by 6 cycles with a single low bit; never two low bits.
4. digit_en=4'b0101 with shadow 16'hABCD -> digits 1 and 3 keep an_out=1111 through SHOW. Digit 0 shows "d" (7'b1000010); digit 2 shows "b" (7'b1100000).
5. update_req held for 3 frames while digits_in changes 16'h0000 -> 16'h0099 mid-frame -> three acks spaced 32 cycles apart; the shadow takes the value present at each frame end.
6. SEG_SCAN_BLINK_EN with BLINK_FRAMES=2 and blink_mask=4'b0001 -> digit 0 is dark for frames 2-3, lit for frames 4-5, and so on; other digits are unaffected.
